// File: rtl/instr_encoder_pkg.sv
// Opcode/funct constants, immediate range limits and the encoder payload type.
package instr_encoder_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned IMM_W   = 64;

   localparam logic [6:0] LD        = 7'b0000011;
   localparam logic [6:0] IMM_ARITH = 7'b0010011;
   localparam logic [6:0] JALR      = 7'b1100111;
   localparam logic [6:0] TYPE_S    = 7'b0100011;
   localparam logic [6:0] TYPE_SB   = 7'b1100011;
   localparam logic [6:0] TYPE_U    = 7'b0110111;
   localparam logic [6:0] TYPE_UJ   = 7'b1101111;

   localparam logic [2:0] F3_SLLI = 3'b001;
   localparam logic [2:0] F3_SRAI = 3'b101;

   localparam logic [6:0] F7_SRAI = 7'b0100000;
   localparam logic [6:0] F7_ZERO = 7'b0000000;

   localparam logic signed [IMM_W-1:0] SHAMT_MIN = 64'sd0;
   localparam logic signed [IMM_W-1:0] SHAMT_MAX = 64'sd31;
   localparam logic signed [IMM_W-1:0] IMM12_MIN = -64'sd2048;
   localparam logic signed [IMM_W-1:0] IMM12_MAX = 64'sd2047;
   localparam logic signed [IMM_W-1:0] SB_MIN    = -64'sd8192;
   localparam logic signed [IMM_W-1:0] SB_MAX    = 64'sd8188;
   localparam logic signed [IMM_W-1:0] UJ_MIN    = -64'sd524288;
   localparam logic signed [IMM_W-1:0] UJ_MAX    = 64'sd524287;
   localparam logic signed [IMM_W-1:0] U_MIN     = -64'sd2147483648;
   localparam logic signed [IMM_W-1:0] U_MAX     = 64'sd2147483647;

   // One encoded word plus its per-word error flag
   typedef struct packed {
      logic               range_err;
      logic [INSTR_W-1:0] instr;
   } enc_word_t;

   // Signed range test on the full 64-bit immediate
   function automatic logic in_range(input logic [IMM_W-1:0] v,
                                     input logic signed [IMM_W-1:0] lo,
                                     input logic signed [IMM_W-1:0] hi);
      return ($signed(v) >= lo) && ($signed(v) <= hi);
   endfunction

endpackage

// File: rtl/instr_encoder_skid_buffer.sv
// Generic 2-entry valid/ready register slice (main + skid register).
module instr_encoder_skid_buffer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic [W-1:0] skid_q;
   logic         skid_empty_q;
   logic         in_fire;

   assign in_ready = skid_empty_q;
   assign in_fire  = in_valid & skid_empty_q;

   // Main register refills from skid first, else from input; skid catches input while stalled
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_data     <= '0;
         skid_q       <= '0;
         skid_empty_q <= 1'b1;
      end else if (!out_valid || out_ready) begin
         if (!skid_empty_q) begin
            out_data     <= skid_q;
            out_valid    <= 1'b1;
            skid_empty_q <= 1'b1;
         end else begin
            out_valid <= in_fire;
            if (in_fire) begin
               out_data <= in_data;
            end
         end
      end else if (in_fire) begin
         skid_q       <= in_data;
         skid_empty_q <= 1'b0;
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded fields and a 64-bit immediate into an RV64 word, with address stamping.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned ADDR_STEP = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [6:0]        i_opcode,
   input  logic [2:0]        i_funct3,
   input  logic [6:0]        i_funct7,
   input  logic [4:0]        i_rd,
   input  logic [4:0]        i_rs1,
   input  logic [4:0]        i_rs2,
   input  logic [IMM_W-1:0]  i_imm,
   input  logic              i_clear,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [31:0]       o_instr,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_range_err,
   output logic              o_err_sticky
);

   enc_word_t enc_c;
   enc_word_t out_word;
   logic      out_fire;

   // Field placement with immediate override and per-opcode range check
   always_comb begin
      enc_c.instr     = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      enc_c.range_err = 1'b0;
      case (i_opcode)
         IMM_ARITH, JALR, LD: begin
            if (i_opcode == IMM_ARITH && (i_funct3 == F3_SLLI || i_funct3 == F3_SRAI)) begin
               enc_c.instr[24:20] = i_imm[4:0];
               enc_c.range_err    = !in_range(i_imm, SHAMT_MIN, SHAMT_MAX);
            end else begin
               enc_c.instr[31:20] = i_imm[11:0];
               enc_c.range_err    = !in_range(i_imm, IMM12_MIN, IMM12_MAX);
            end
         end
         TYPE_S: begin
            enc_c.instr[31:25] = i_imm[11:5];
            enc_c.instr[11:7]  = i_imm[4:0];
            enc_c.range_err    = !in_range(i_imm, IMM12_MIN, IMM12_MAX);
         end
         TYPE_SB: begin
            enc_c.instr[31]    = i_imm[13];
            enc_c.instr[7]     = i_imm[12];
            enc_c.instr[30:25] = i_imm[11:6];
            enc_c.instr[11:8]  = i_imm[5:2];
            enc_c.range_err    = !in_range(i_imm, SB_MIN, SB_MAX) || (i_imm[1:0] != 2'b00);
         end
         TYPE_U: begin
            enc_c.instr[31:12] = i_imm[31:12];
            enc_c.range_err    = !in_range(i_imm, U_MIN, U_MAX) || (i_imm[11:0] != 12'h000);
         end
         TYPE_UJ: begin
            enc_c.instr[31]    = i_imm[19];
            enc_c.instr[19:12] = i_imm[18:11];
            enc_c.instr[20]    = i_imm[10];
            enc_c.instr[30:21] = i_imm[9:0];
            enc_c.range_err    = !in_range(i_imm, UJ_MIN, UJ_MAX);
         end
         default: begin
            enc_c.range_err = 1'b1;
         end
      endcase
   end

   instr_encoder_skid_buffer #(
      .W($bits(enc_word_t))
   ) u_skid (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .in_valid  (i_valid),
      .in_ready  (o_ready),
      .in_data   (enc_c),
      .out_valid (o_valid),
      .out_ready (i_ready),
      .out_data  (out_word)
   );

   assign o_instr     = out_word.instr;
   assign o_range_err = out_word.range_err;
   assign out_fire    = o_valid & i_ready;

   // Address counter and sticky error; clear beats increment/set in the same cycle
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_addr       <= '0;
         o_err_sticky <= 1'b0;
      end else if (i_clear) begin
         o_addr       <= '0;
         o_err_sticky <= 1'b0;
      end else if (out_fire) begin
         o_addr <= o_addr + ADDR_W'(ADDR_STEP);
         if (out_word.range_err) begin
            o_err_sticky <= 1'b1;
         end
      end
   end

endmodule
